// File: rtl/tank_pkg.sv
// ============================================================================
// Module      : tank_pkg
// Description : Shared types and playfield constants for the tank shot logic.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package tank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        RESOLVE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PLAYER_NONE = 2'd0,
        PLAYER_1    = 2'd1,
        PLAYER_2    = 2'd2
    } player_e;

    // Wide enough that velocities added to on-screen positions never wrap.
    typedef logic signed [11:0] pos_t;

    localparam int X_MIN       = 0;
    localparam int X_MAX       = 639;
    localparam int Y_GROUND    = 440;
    localparam int TANK_HALF_W = 16;
    localparam int TANK_H      = 20;

    function automatic logic [9:0] clamp10(input pos_t v);
        if (v < pos_t'(0))
            return 10'd0;
        else if (v > pos_t'(1023))
            return 10'd1023;
        else
            return v[9:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/turn_projectile_ctrl_if.sv
// ============================================================================
// Module      : turn_projectile_ctrl_if
// Description : Turn/fire inputs and shot/health outputs of the shell block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface turn_projectile_ctrl_if;
    logic              new_game;
    logic              player1flag;
    logic              player2flag;
    logic              fire;
    logic signed [7:0] vx;
    logic signed [7:0] vy;
    logic [9:0]        tank1_x;
    logic [9:0]        tank2_x;
    logic [9:0]        tank_y;
    logic              bull_shoot_flag1;
    logic              bull_shoot_flag2;
    logic              bull_stop_flag1;
    logic              bull_stop_flag2;
    logic              bullet_active;
    logic [9:0]        bullet_x;
    logic [9:0]        bullet_y;
    logic [3:0]        health_1;
    logic [3:0]        health_2;

    modport master (
        output new_game, player1flag, player2flag, fire, vx, vy,
               tank1_x, tank2_x, tank_y,
        input  bull_shoot_flag1, bull_shoot_flag2, bull_stop_flag1,
               bull_stop_flag2, bullet_active, bullet_x, bullet_y,
               health_1, health_2
    );

    modport slave (
        input  new_game, player1flag, player2flag, fire, vx, vy,
               tank1_x, tank2_x, tank_y,
        output bull_shoot_flag1, bull_shoot_flag2, bull_stop_flag1,
               bull_stop_flag2, bullet_active, bullet_x, bullet_y,
               health_1, health_2
    );
endinterface

`default_nettype wire

// File: rtl/projectile_step.sv
// ============================================================================
// Module      : projectile_step
// Description : One-frame ballistic step of a shell plus hit/miss classification.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module projectile_step
    import tank_pkg::*;
#(
    parameter int GRAVITY = 1
) (
    input  pos_t       i_x,
    input  pos_t       i_y,
    input  pos_t       i_vx,
    input  pos_t       i_vy,
    input  logic [9:0] i_target_x,
    input  logic [9:0] i_tank_y,
    output pos_t       o_nx,
    output pos_t       o_ny,
    output pos_t       o_nvy,
    output logic       o_hit,
    output logic       o_miss
);

    pos_t w_dx;
    pos_t w_adx;
    pos_t w_top;

    always_comb begin
        o_nx  = i_x + i_vx;
        o_nvy = i_vy + pos_t'(GRAVITY);
        o_ny  = i_y + o_nvy;

        w_dx  = o_nx - pos_t'({2'b00, i_target_x});
        w_adx = (w_dx < pos_t'(0)) ? -w_dx : w_dx;
        w_top = pos_t'({2'b00, i_tank_y}) - pos_t'(TANK_H);

        // Negative y (shell above the screen) is deliberately not a miss.
        o_hit  = (w_adx <= pos_t'(TANK_HALF_W)) && (o_ny >= w_top);
        o_miss = (o_nx < pos_t'(X_MIN)) || (o_nx > pos_t'(X_MAX)) ||
                 (o_ny >= pos_t'(Y_GROUND));
    end

endmodule

`default_nettype wire

// File: rtl/turn_projectile_ctrl.sv
// ============================================================================
// Module      : turn_projectile_ctrl
// Description : Launches, flies and resolves one shell per turn; keeps health.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module turn_projectile_ctrl
    import tank_pkg::*;
#(
    parameter int GRAVITY    = 1,
    parameter int DAMAGE     = 1,
    parameter int MAX_HEALTH = 5
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    turn_projectile_ctrl_if.slave   bus
);

    localparam logic [3:0] HEALTH_INIT = 4'(MAX_HEALTH);
    localparam logic [3:0] HEALTH_DMG  = 4'(DAMAGE);

    state_e     state_q,   state_d;
    player_e    shooter_q, shooter_d;
    pos_t       x_q,  x_d;
    pos_t       y_q,  y_d;
    pos_t       vx_q, vx_d;
    pos_t       vy_q, vy_d;
    logic       shoot1_q, shoot1_d;
    logic       shoot2_q, shoot2_d;
    logic       stop1_q,  stop1_d;
    logic       stop2_q,  stop2_d;
    logic       active_q, active_d;
    logic [3:0] health1_q, health1_d;
    logic [3:0] health2_q, health2_d;
    logic       fire_q;

    player_e    w_owner;
    logic       w_fire_rise;
    pos_t       w_vx_ext;
    logic [9:0] w_target_x;
    pos_t       w_nx, w_ny, w_nvy;
    logic       w_hit, w_miss;

    assign w_fire_rise = bus.fire & ~fire_q;
    assign w_vx_ext    = {{4{bus.vx[7]}}, bus.vx};
    assign w_target_x  = (shooter_q == PLAYER_1) ? bus.tank2_x : bus.tank1_x;

    always_comb begin
        w_owner = PLAYER_NONE;
        if (bus.player1flag && !bus.player2flag)
            w_owner = PLAYER_1;
        else if (bus.player2flag && !bus.player1flag)
            w_owner = PLAYER_2;
    end

    projectile_step #(
        .GRAVITY (GRAVITY)
    ) u_step (
        .i_x        (x_q),
        .i_y        (y_q),
        .i_vx       (vx_q),
        .i_vy       (vy_q),
        .i_target_x (w_target_x),
        .i_tank_y   (bus.tank_y),
        .o_nx       (w_nx),
        .o_ny       (w_ny),
        .o_nvy      (w_nvy),
        .o_hit      (w_hit),
        .o_miss     (w_miss)
    );

    always_comb begin
        state_d   = state_q;
        shooter_d = shooter_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        shoot1_d  = 1'b0;
        shoot2_d  = 1'b0;
        stop1_d   = 1'b0;
        stop2_d   = 1'b0;
        active_d  = active_q;
        health1_d = health1_q;
        health2_d = health2_q;

        case (state_q)
            IDLE: begin
                if (w_fire_rise && (w_owner != PLAYER_NONE)) begin
                    shooter_d = w_owner;
                    x_d       = (w_owner == PLAYER_1) ? pos_t'({2'b00, bus.tank1_x})
                                                      : pos_t'({2'b00, bus.tank2_x});
                    y_d       = pos_t'({2'b00, bus.tank_y}) - pos_t'(TANK_H + 1);
                    vx_d      = (w_owner == PLAYER_1) ? w_vx_ext : -w_vx_ext;
                    vy_d      = {{4{bus.vy[7]}}, bus.vy};
                    shoot1_d  = (w_owner == PLAYER_1);
                    shoot2_d  = (w_owner == PLAYER_2);
                    active_d  = 1'b1;
                    state_d   = FLY;
                end
            end

            FLY: begin
                // Health and stop pulse land on the same edge so the game FSM
                // sees final health when it samples the stop flag.
                if (w_hit || w_miss) begin
                    stop1_d  = (shooter_q == PLAYER_1);
                    stop2_d  = (shooter_q == PLAYER_2);
                    active_d = 1'b0;
                    state_d  = RESOLVE;
                    if (w_hit) begin
                        if (shooter_q == PLAYER_1)
                            health2_d = (health2_q >= HEALTH_DMG) ? health2_q - HEALTH_DMG : 4'd0;
                        else
                            health1_d = (health1_q >= HEALTH_DMG) ? health1_q - HEALTH_DMG : 4'd0;
                    end
                end else begin
                    x_d  = w_nx;
                    y_d  = w_ny;
                    vy_d = w_nvy;
                end
            end

            RESOLVE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        fire_q <= bus.fire;
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset || bus.new_game) begin
            state_q   <= IDLE;
            shooter_q <= PLAYER_NONE;
            x_q       <= '0;
            y_q       <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            shoot1_q  <= 1'b0;
            shoot2_q  <= 1'b0;
            stop1_q   <= 1'b0;
            stop2_q   <= 1'b0;
            active_q  <= 1'b0;
            health1_q <= HEALTH_INIT;
            health2_q <= HEALTH_INIT;
        end else begin
            state_q   <= state_d;
            shooter_q <= shooter_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            shoot1_q  <= shoot1_d;
            shoot2_q  <= shoot2_d;
            stop1_q   <= stop1_d;
            stop2_q   <= stop2_d;
            active_q  <= active_d;
            health1_q <= health1_d;
            health2_q <= health2_d;
        end
    end

    assign bus.bull_shoot_flag1 = shoot1_q;
    assign bus.bull_shoot_flag2 = shoot2_q;
    assign bus.bull_stop_flag1  = stop1_q;
    assign bus.bull_stop_flag2  = stop2_q;
    assign bus.bullet_active    = active_q;
    assign bus.bullet_x         = clamp10(x_q);
    assign bus.bullet_y         = clamp10(y_q);
    assign bus.health_1         = health1_q;
    assign bus.health_2         = health2_q;

endmodule

`default_nettype wire

// File: doc/turn_projectile_ctrl.md
Name: turn_projectile_ctrl

Overview:
- Produces the shot-lifecycle flags and player health values that the turn-sequencing game FSM consumes.
- When the FSM grants a player's turn, the block latches that player's fire request and launches a shell.
- It integrates the shell's ballistic flight once per frame, then resolves it as a hit or a miss.
- On resolution it pulses the stop flag and updates health, which the FSM then checks for game end.

Parameters:
- X_MIN, 0, left playfield bound in pixels
- X_MAX, 639, right playfield bound in pixels
- Y_GROUND, 440, ground line; y >= Y_GROUND is a miss
- TANK_HALF_W, 16, horizontal hit half-width around the tank centre
- TANK_H, 20, hit height above tank_y
- GRAVITY, 1, added to vertical velocity each frame
- DAMAGE, 1, health lost per hit
- MAX_HEALTH, 5, health value loaded on reset and on new_game

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-low reset
- new_game  in  1  level; the FSM start-screen indication; restores health and clears the shell
- player1flag  in  1  level; player 1 may fire
- player2flag  in  1  level; player 2 may fire
- fire  in  1  level fire key; the block uses its rising edge
- vx  in  8 signed  launch horizontal velocity in pixels/frame, firer-relative (positive = toward opponent)
- vy  in  8 signed  launch vertical velocity; negative = upward
- tank1_x, tank2_x  in  10 each  tank centre x positions
- tank_y  in  10  tank base y, shared by both tanks
- bull_shoot_flag1, bull_shoot_flag2  out  1 each  one-cycle pulse at launch
- bull_stop_flag1, bull_stop_flag2  out  1 each  one-cycle pulse at resolution
- bullet_active  out  1  high while the shell is in flight
- bullet_x, bullet_y  out  10 each  shell position for rendering
- health_1, health_2  out  4 each  player health

Behaviour:
- Reset low at an edge:
  - state goes to IDLE.
  - All flags are 0 and bullet_active is 0.
  - bullet_x and bullet_y are 0.
  - health_1 and health_2 are loaded with MAX_HEALTH.
- new_game high (Reset high): same effect as reset. Reset takes priority over new_game.
- fire_q is a registered copy of fire. fire_rise = fire & ~fire_q.
- Turn owner:
  - owner = 1 if player1flag & ~player2flag.
  - owner = 2 if player2flag & ~player1flag.
  - owner = none otherwise; both flags high is treated as none.
- IDLE:
  - Waits for fire_rise with an owner.
  - At that edge it latches the shooter and loads the shell:
    - x = the shooter's tank x.
    - y = tank_y - TANK_H - 1.
    - vx_cur = +vx for player 1, -vx for player 2.
    - vy_cur = vy.
  - It pulses bull_shoot_flag of the shooter for exactly that one cycle, sets bullet_active, and goes to FLY.
  - fire_rise with no owner is ignored.
- FLY: on every edge, compute nx = x + vx_cur, nvy = vy_cur + GRAVITY, ny = y + nvy. Then evaluate, in priority order:
  1. Hit: |nx - target_x| <= TANK_HALF_W and ny >= tank_y - TANK_H, where target is the non-shooter tank. Go to RESOLVE with hit = 1.
  2. Miss: nx < X_MIN, or nx > X_MAX, or ny >= Y_GROUND. Go to RESOLVE with hit = 0.
  3. Otherwise commit nx/nvy/ny and stay in FLY.
- FLY arithmetic:
  - All position arithmetic is 12-bit signed, sign-extended, so there is no wrap-around.
  - Outputs are clamped to 0..1023.
  - Upward shells may have negative y; that alone is not a miss.
  - Player flags and fire are ignored while in FLY.
- RESOLVE (one cycle):
  - Pulse bull_stop_flag of the shooter.
  - Clear bullet_active.
  - If hit: target health -= DAMAGE, saturating at 0.
  - The health update and the stop pulse are registered on the same edge, so health is already valid when the FSM samples the stop flag.
  - Next state is IDLE.
- Shot latency: the shoot pulse occurs on the cycle after the fire rise is sampled. Flight length is at least 1 frame.
- Health is never modified outside RESOLVE, reset and new_game.
- Self-hit is impossible because only the opponent tank is tested.

Decomposition:
- Package tank_pkg holds:
  - the state enum {IDLE, FLY, RESOLVE}
  - the player id typedef
  - shared playfield constants (X_MIN, X_MAX, Y_GROUND, TANK_HALF_W, TANK_H)
- One sub-module, projectile_step: combinational next-position computation plus hit/miss classification. It is reusable by a future trajectory-preview block.

Test Plan:
- Reset low for 2 cycles with a shell mid-flight -> bullet_active = 0, all flags 0, health_1 = health_2 = 5.
- player1flag = 1, fire rises, vx = 4, vy = -10, tank1_x = 100 -> bull_shoot_flag1 is high for exactly 1 cycle, bullet_x = 100, bullet_active = 1.
- Player 1 shot aimed to land on tank2_x = 300 -> exactly one bull_stop_flag1 pulse, and health_2 goes from 5 to 4 on the same edge.
- Player 2 shot with vx = 20 toward x < 0 -> miss on the edge where nx < 0, bull_stop_flag2 pulses, both healths unchanged.
- health_1 = 0 and another hit lands on tank 1 -> health_1 stays 0; with both player flags high, a fire rise produces no shoot flag.
- new_game pulsed after health_2 = 0 -> both healths are 5 next cycle, state is IDLE, no flags pulse.
